// File: rtl/airlock_pkg.sv
// -----------------------------------------------------------------------------
// airlock_pkg
// Shared types and defaults for the two-door airlock sequencer.
//   state_t : sequencer FSM states (idle, timer phases, door phases)
//   dir_t   : direction of the vessel currently in transit
//   DEF_*   : default counter width and countdown lengths
//   is_idle : true for the two resting states
// -----------------------------------------------------------------------------
package airlock_pkg;

  localparam int DEF_W          = 10;
  localparam int DEF_PRESS_SECS = 5;
  localparam int DEF_EVAC_SECS  = 8;

  typedef enum logic [3:0] {
    IDLE_P,     // chamber pressurized, doors shut
    IDLE_E,     // chamber evacuated, doors shut
    EVAC_LD,    // start pulse to counter, evacuate length
    EVAC_SET,   // counter load latency, feedback ignored
    EVAC_WT,    // wait for counter to reach zero
    PRESS_LD,
    PRESS_SET,
    PRESS_WT,
    OUTER_OPN,  // outer door open until passDone
    INNER_OPN   // inner door open until passDone
  } state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  function automatic logic is_idle(input state_t s);
    return (s == IDLE_P) || (s == IDLE_E);
  endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// -----------------------------------------------------------------------------
// airlock_sequencer_if
// Bundles the sequencer's sensor inputs, counter handshake and door/status
// outputs.
//   master : the sequencer (drives beginCount/counterSeconds and status)
//   slave  : the environment (sensors, counter peer, display/actuators)
// Signals:
//   arrive, depart   level requests from vessel sensors
//   passDone         1-cycle pulse, vessel cleared the open door
//   signal           counter remaining count, 0 = expired/idle
//   beginCount       1-cycle start pulse to the counter
//   counterSeconds   countdown value presented with beginCount
//   outerOpen, innerOpen, pressurizing, evacuating, busy : status outputs
// -----------------------------------------------------------------------------
interface airlock_sequencer_if #(
  parameter int W = 10
);

  logic         arrive;
  logic         depart;
  logic         passDone;
  logic [W-1:0] signal;
  logic         beginCount;
  logic [W-1:0] counterSeconds;
  logic         outerOpen;
  logic         innerOpen;
  logic         pressurizing;
  logic         evacuating;
  logic         busy;

  modport master (
    input  arrive, depart, passDone, signal,
    output beginCount, counterSeconds, outerOpen, innerOpen,
           pressurizing, evacuating, busy
  );

  modport slave (
    output arrive, depart, passDone, signal,
    input  beginCount, counterSeconds, outerOpen, innerOpen,
           pressurizing, evacuating, busy
  );

endinterface

// File: rtl/airlock_sequencer.sv
// -----------------------------------------------------------------------------
// airlock_sequencer
// Initiator side of a timed-countdown handshake controlling a two-door
// airlock. Sequences the doors and requests pressurize/evacuate countdowns
// from a peer counter, advancing only when the counter reports zero.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    airlock_sequencer_if.master (sensors, counter handshake, status)
// Every output is a pure decode of the registered state (Moore machine),
// so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int PRESS_SECS = DEF_PRESS_SECS,
  parameter int EVAC_SECS  = DEF_EVAC_SECS
) (
  input  logic                clk,
  input  logic                reset,
  airlock_sequencer_if.master bus
);

  localparam logic [W-1:0] PRESS_CNT = W'(PRESS_SECS);
  localparam logic [W-1:0] EVAC_CNT  = W'(EVAC_SECS);

  state_t state, state_next;
  dir_t   dir,   dir_next;
  // phase=1 means the open door was reached through a timer, i.e. this is
  // the last door of the transit and passDone returns the chamber to idle.
  logic   phase, phase_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE_P;
      dir   <= DIR_IN;
      phase <= 1'b0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      phase <= phase_next;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    phase_next = phase;
    case (state)
      IDLE_P: begin
        // Chamber already pressurized: an outbound vessel enters directly.
        if (bus.depart) begin
          state_next = INNER_OPN;
          dir_next   = DIR_OUT;
          phase_next = 1'b0;
        end else if (bus.arrive) begin
          state_next = EVAC_LD;
          dir_next   = DIR_IN;
        end
      end
      IDLE_E: begin
        // Chamber already evacuated: an inbound vessel enters directly.
        if (bus.arrive) begin
          state_next = OUTER_OPN;
          dir_next   = DIR_IN;
          phase_next = 1'b0;
        end else if (bus.depart) begin
          state_next = PRESS_LD;
          dir_next   = DIR_OUT;
        end
      end
      EVAC_LD:   state_next = EVAC_SET;
      // The counter still shows its old value during the load cycle.
      EVAC_SET:  state_next = EVAC_WT;
      EVAC_WT: begin
        if (bus.signal == '0) begin
          state_next = OUTER_OPN;
          phase_next = 1'b1;
        end
      end
      PRESS_LD:  state_next = PRESS_SET;
      PRESS_SET: state_next = PRESS_WT;
      PRESS_WT: begin
        if (bus.signal == '0) begin
          state_next = INNER_OPN;
          phase_next = 1'b1;
        end
      end
      OUTER_OPN: begin
        if (bus.passDone) state_next = phase ? IDLE_E : PRESS_LD;
      end
      INNER_OPN: begin
        if (bus.passDone) state_next = phase ? IDLE_P : EVAC_LD;
      end
      default: state_next = IDLE_P;
    endcase
  end

  always_comb begin
    bus.beginCount     = 1'b0;
    bus.counterSeconds = '0;
    bus.outerOpen      = 1'b0;
    bus.innerOpen      = 1'b0;
    bus.pressurizing   = 1'b0;
    bus.evacuating     = 1'b0;
    bus.busy           = !is_idle(state);
    case (state)
      EVAC_LD: begin
        bus.beginCount     = 1'b1;
        bus.counterSeconds = EVAC_CNT;
        bus.evacuating     = 1'b1;
      end
      EVAC_SET, EVAC_WT: begin
        bus.counterSeconds = EVAC_CNT;
        bus.evacuating     = 1'b1;
      end
      PRESS_LD: begin
        bus.beginCount     = 1'b1;
        bus.counterSeconds = PRESS_CNT;
        bus.pressurizing   = 1'b1;
      end
      PRESS_SET, PRESS_WT: begin
        bus.counterSeconds = PRESS_CNT;
        bus.pressurizing   = 1'b1;
      end
      OUTER_OPN: bus.outerOpen = 1'b1;
      INNER_OPN: bus.innerOpen = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_airlock_sequencer
// Directed bench for airlock_sequencer with a behavioural counter peer that
// loads on the edge where beginCount is high and then decrements once per
// clock. Countdowns are shortened to PRESS=3, EVAC=4. Outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_airlock_sequencer;

  localparam int W     = 10;
  localparam int PRESS = 3;
  localparam int EVAC  = 4;

  logic clk;
  logic reset;

  airlock_sequencer_if #(.W(W)) bus ();

  airlock_sequencer #(
    .W          (W),
    .PRESS_SECS (PRESS),
    .EVAC_SECS  (EVAC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter peer model, with an override used to freeze it or inject a
  // stale value.
  logic [W-1:0] cnt;
  logic         force_en;
  logic [W-1:0] force_val;

  always @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (bus.beginCount) cnt <= bus.counterSeconds;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign bus.signal = force_en ? force_val : cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed output vector: {beginCount, counterSeconds, outerOpen, innerOpen,
  // pressurizing, evacuating, busy}.
  function automatic logic [15:0] exp_v(input logic bc, input logic [W-1:0] cs,
                                        input logic oo, input logic io,
                                        input logic pr, input logic ev,
                                        input logic bz);
    return {bc, cs, oo, io, pr, ev, bz};
  endfunction

  task automatic outs(input string tag, input logic [15:0] exp);
    check(tag, {16'h0, bus.beginCount, bus.counterSeconds, bus.outerOpen,
                bus.innerOpen, bus.pressurizing, bus.evacuating, bus.busy},
          {16'h0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pass_pulse();
    bus.passDone = 1'b1;
    step();
    bus.passDone = 1'b0;
  endtask

  // Called while the DUT sits in X_LD; leaves it in the last X_WT cycle
  // (counter reads 0), so the next step enters the door state.
  task automatic timer_walk(input bit evac, input string tag);
    logic [15:0] base;
    int n;
    base = evac ? exp_v(1'b0, W'(EVAC), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)
                : exp_v(1'b0, W'(PRESS), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n = evac ? EVAC : PRESS;
    outs({tag, "_ld"}, base | 16'h8000);
    step();
    outs({tag, "_set"}, base);
    for (int i = 0; i < n; i++) begin
      step();
      outs({tag, "_wt"}, base);
    end
  endtask

  logic [15:0] v_idle, v_outer, v_inner, v_press;

  initial begin
    v_idle  = 16'h0;
    v_outer = exp_v(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    v_inner = exp_v(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    v_press = exp_v(1'b0, W'(PRESS), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    reset        = 1'b1;
    bus.arrive   = 1'b0;
    bus.depart   = 1'b0;
    bus.passDone = 1'b0;
    force_en     = 1'b0;
    force_val    = '0;

    // Reset
    step(); step();
    outs("reset", v_idle);
    reset = 1'b0;
    step();
    outs("idle_after_reset", v_idle);

    // Arrive from IDLE_P: evacuate, outer door, then idle evacuated
    bus.arrive = 1'b1; step(); bus.arrive = 1'b0;
    timer_walk(1'b1, "arr_evac");
    step(); outs("arr_outer", v_outer);
    pass_pulse(); outs("arr_idle_e", v_idle);
    // Depart from IDLE_E: pressurize, inner door, then idle pressurized
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    timer_walk(1'b0, "arr_press");
    step(); outs("arr_inner", v_inner);
    pass_pulse(); outs("arr_idle_p", v_idle);

    // Depart from IDLE_P: inner door at once, then evacuate, outer door
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    outs("dep_inner", v_inner);
    pass_pulse();
    timer_walk(1'b1, "dep_evac");
    step(); outs("dep_outer", v_outer);
    pass_pulse(); outs("dep_idle_e", v_idle);

    // Both requests in IDLE_E: arrive wins
    bus.arrive = 1'b1; bus.depart = 1'b1; step();
    bus.arrive = 1'b0; bus.depart = 1'b0;
    outs("both_e_outer", v_outer);
    pass_pulse();
    timer_walk(1'b0, "both_e_press");
    step(); outs("both_e_inner", v_inner);
    pass_pulse(); outs("both_e_idle_p", v_idle);
    // Both requests in IDLE_P: depart wins
    bus.arrive = 1'b1; bus.depart = 1'b1; step();
    bus.arrive = 1'b0; bus.depart = 1'b0;
    outs("both_p_inner", v_inner);
    pass_pulse();
    timer_walk(1'b1, "both_p_evac");
    step(); outs("both_p_outer", v_outer);
    pass_pulse(); outs("both_p_idle_e", v_idle);

    // passDone and arrive during PRESS_WT are ignored
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    outs("pd_ld", v_press | 16'h8000);
    step(); outs("pd_set", v_press);
    step(); outs("pd_wt2", v_press);
    bus.passDone = 1'b1; bus.arrive = 1'b1; step();
    bus.passDone = 1'b0; bus.arrive = 1'b0;
    outs("pd_wt1_ignored", v_press);
    step(); outs("pd_wt0", v_press);
    step(); outs("pd_inner", v_inner);
    pass_pulse(); outs("pd_idle_p", v_idle);
    // passDone in idle and a stale nonzero count are ignored
    pass_pulse(); outs("pd_in_idle", v_idle);
    force_en = 1'b1; force_val = W'(5);
    step(); step();
    outs("stale_signal", v_idle);
    force_en = 1'b0;
    // Still in IDLE_P: depart goes straight to the inner door
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    outs("still_idle_p", v_inner);
    pass_pulse();
    timer_walk(1'b1, "pd_evac");
    step(); outs("pd_outer", v_outer);
    pass_pulse(); outs("pd_idle_e", v_idle);

    // Reset in the middle of EVAC_WT (reach it via IDLE_E->PRESS->IDLE_P)
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    timer_walk(1'b0, "rst_press");
    step(); pass_pulse(); outs("rst_idle_p", v_idle);
    bus.arrive = 1'b1; step(); bus.arrive = 1'b0;
    step(); step(); step();
    outs("rst_in_evac_wt", exp_v(1'b0, W'(EVAC), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    reset = 1'b1; step(); reset = 1'b0;
    outs("reset_mid_op", v_idle);
    // Back in IDLE_P (not IDLE_E): depart opens the inner door
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    outs("post_reset_idle_p", v_inner);
    pass_pulse();
    timer_walk(1'b1, "post_rst_evac");
    step(); outs("post_rst_outer", v_outer);
    pass_pulse(); outs("post_rst_idle_e", v_idle);

    // Counter frozen at 2: PRESS_WT holds with doors shut
    force_en = 1'b1; force_val = W'(2);
    bus.depart = 1'b1; step(); bus.depart = 1'b0;
    outs("frz_ld", v_press | 16'h8000);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      outs("frz_hold", v_press);
    end
    force_en = 1'b0;
    step(); outs("frz_release_inner", v_inner);
    pass_pulse(); outs("frz_idle_p", v_idle);

    // Random run: doors never open together, never open during a timer
    for (int i = 0; i < 2000; i++) begin
      bus.arrive   = 1'($urandom_range(0, 1));
      bus.depart   = 1'($urandom_range(0, 1));
      bus.passDone = ($urandom_range(0, 3) == 0);
      step();
      check("door_excl", {31'h0, bus.outerOpen & bus.innerOpen}, 32'h0);
      check("door_in_timer",
            {31'h0, (bus.outerOpen | bus.innerOpen) & (bus.pressurizing | bus.evacuating)},
            32'h0);
    end
    bus.arrive   = 1'b0;
    bus.depart   = 1'b0;
    bus.passDone = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
